// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - registered N-to-log2(N) priority encoder, fixed or round-robin, valid/ready on both sides
module prio_enc_rr #(
  parameter int N         = 4,
  parameter int IDXW      = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    req,
  input  logic            rr_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_any,
  output logic [N-1:0]    out_onehot
);

  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_any_q, out_any_d;
  logic [N-1:0]    out_onehot_q, out_onehot_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic            accept;
  logic            pop;
  int              pos;

  // Candidates are scanned from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    pos     = 0;
    if (rr_mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        pos = int'(rr_ptr_q) + k;
        if (pos >= N) pos = pos - N;
        if (req[pos]) begin
          win_idx = IDXW'(pos);
          win_any = 1'b1;
        end
      end
    end else if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          win_idx = IDXW'(i);
          win_any = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_idx = IDXW'(i);
          win_any = 1'b1;
        end
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_any_d    = out_any_q;
    out_onehot_d = out_onehot_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_idx_d    = win_idx;
      out_any_d    = win_any;
      out_onehot_d = win_any ? (N'(1) << win_idx) : '0;
      // Explicit wrap keeps the pointer below N even when N is not a power of two.
      if (rr_mode && win_any) begin
        rr_ptr_d = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_any_q    <= 1'b0;
      out_onehot_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_any_q    <= out_any_d;
      out_onehot_q <= out_onehot_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_any    = out_any_q;
  assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb/tb_prio_enc_rr.sv - scoreboard bench for prio_enc_rr, MSB-first and LSB-first instances side by side
module tb_prio_enc_rr;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] req;
  logic       rr_mode;
  logic       out_ready;

  logic       in_ready_m, out_valid_m, out_any_m;
  logic [1:0] out_idx_m;
  logic [3:0] out_onehot_m;
  logic       in_ready_l, out_valid_l, out_any_l;
  logic [1:0] out_idx_l;
  logic [3:0] out_onehot_l;

  int vectors;
  int miscompares;
  bit done;

  logic [2:0] q_m[$];
  logic [2:0] q_l[$];

  prio_enc_rr #(.N(4), .IDXW(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .req(req), .rr_mode(rr_mode), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_idx(out_idx_m), .out_any(out_any_m), .out_onehot(out_onehot_m)
  );

  prio_enc_rr #(.N(4), .IDXW(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .req(req), .rr_mode(rr_mode), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_idx(out_idx_l), .out_any(out_any_l), .out_onehot(out_onehot_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [2:0] e, input logic [1:0] idx,
                         input logic any, input logic [3:0] oh);
    logic [3:0] e_oh;
    e_oh = e[2] ? (4'b0001 << e[1:0]) : 4'b0000;
    chk({tag, "_idx"}, int'(idx), int'(e[1:0]));
    chk({tag, "_any"}, int'(any), int'(e[2]));
    chk({tag, "_onehot"}, int'(oh), int'(e_oh));
  endtask

  task automatic monitor();
    logic [2:0] e;
    while (!done) begin
      @(negedge clk);
      if (!rst && out_ready) begin
        if (out_valid_m) begin
          if (q_m.size() == 0) begin
            miscompares++;
            $display("FAIL msb_unexpected: got idx %0d with no expected beat", out_idx_m);
          end else begin
            e = q_m.pop_front();
            cmp_out("msb", e, out_idx_m, out_any_m, out_onehot_m);
          end
        end
        if (out_valid_l) begin
          if (q_l.size() == 0) begin
            miscompares++;
            $display("FAIL lsb_unexpected: got idx %0d with no expected beat", out_idx_l);
          end else begin
            e = q_l.pop_front();
            cmp_out("lsb", e, out_idx_l, out_any_l, out_onehot_l);
          end
        end
      end
    end
  endtask

  // Presents one beat and returns just after the accepting edge with in_valid still high.
  task automatic beat(input logic [3:0] r, input logic m, input int e_idx,
                      input logic e_any, input int e_idx_l);
    int n;
    in_valid = 1'b1;
    req      = r;
    rr_mode  = m;
    q_m.push_back({e_any, 2'(e_idx)});
    q_l.push_back({e_any, 2'(e_idx_l)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_m && n < 50);
    if (!in_ready_m) begin
      miscompares++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    chk("latency_valid_msb", int'(out_valid_m), 1);
    chk("latency_valid_lsb", int'(out_valid_l), 1);
  endtask

  task automatic stimulus();
    int n;
    // T1 reset held with a live request
    rst = 1'b1; in_valid = 1'b1; req = 4'b1111; rr_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_m), 0);
    chk("rst_out_idx", int'(out_idx_m), 0);
    chk("rst_out_onehot", int'(out_onehot_m), 0);
    chk("rst_out_any", int'(out_any_m), 0);
    chk("rst_in_ready", int'(in_ready_m), 1);
    chk("rst_out_valid_lsb", int'(out_valid_l), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // T2 fixed priority, back to back
    beat(4'b0001, 1'b0, 0, 1'b1, 0);
    beat(4'b0010, 1'b0, 1, 1'b1, 1);
    beat(4'b0100, 1'b0, 2, 1'b1, 2);
    beat(4'b1000, 1'b0, 3, 1'b1, 3);
    beat(4'b0110, 1'b0, 2, 1'b1, 1);
    beat(4'b0000, 1'b0, 0, 1'b0, 0);
    beat(4'b1011, 1'b0, 3, 1'b1, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // T3 backpressure, then pop and accept on the same edge
    beat(4'b1000, 1'b0, 3, 1'b1, 3);
    out_ready = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready_m), 0);
      chk("bp_out_valid", int'(out_valid_m), 1);
      chk("bp_out_idx", int'(out_idx_m), 3);
      chk("bp_out_idx_lsb", int'(out_idx_l), 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    beat(4'b0001, 1'b0, 0, 1'b1, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // T4 round-robin rotation from pointer 0
    beat(4'b1111, 1'b1, 0, 1'b1, 0);
    beat(4'b1111, 1'b1, 1, 1'b1, 1);
    beat(4'b1111, 1'b1, 2, 1'b1, 2);
    beat(4'b1111, 1'b1, 3, 1'b1, 3);
    beat(4'b1111, 1'b1, 0, 1'b1, 0);
    beat(4'b1010, 1'b1, 1, 1'b1, 1);
    beat(4'b1010, 1'b1, 3, 1'b1, 3);

    // T5 wrap and zero request; pointer is 0 here
    beat(4'b0100, 1'b1, 2, 1'b1, 2);
    beat(4'b0011, 1'b1, 0, 1'b1, 0);
    beat(4'b0000, 1'b1, 0, 1'b0, 0);
    beat(4'b0011, 1'b1, 1, 1'b1, 1);
    // mode switch: fixed beat leaves the pointer at 2
    beat(4'b1111, 1'b0, 3, 1'b1, 0);
    beat(4'b1111, 1'b1, 2, 1'b1, 2);
    beat(4'b1001, 1'b1, 3, 1'b1, 3);
    beat(4'b1111, 1'b1, 0, 1'b1, 0);
    beat(4'b1000, 1'b1, 3, 1'b1, 3);
    beat(4'b0100, 1'b1, 2, 1'b1, 2);
    beat(4'b0010, 1'b1, 1, 1'b1, 1);

    // T6 reset with a stalled result and pointer at 2
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_valid", int'(out_valid_m), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    q_m.delete();
    q_l.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", int'(out_valid_m), 0);
    chk("t6_out_valid_lsb", int'(out_valid_l), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    beat(4'b1111, 1'b1, 0, 1'b1, 0);
    in_valid = 1'b0;

    n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q_m.size() != 0 || q_l.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d beats outstanding expected 0", q_m.size(), q_l.size());
    end
    repeat (2) @(posedge clk);
    done = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    done = 1'b0;
    rst = 1'b1; in_valid = 1'b0; req = '0; rr_mode = 1'b0; out_ready = 1'b1;
    fork
      monitor();
      stimulus();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
